// File: rtl/poly_negacyclic_accumulator.sv
// Negacyclic polynomial accumulator: folds three partial-product lanes per beat
// into DEPTH coefficients mod (x^DEPTH + 1), mod 2^16, then drains the finished
// polynomial over a valid/ready handshake and self-clears.
//
// state  | meaning
// IDLE   | waiting for first beat of a frame; accumulator is zero
// ACCUM  | frame in progress, beats accepted
// DRAIN  | streaming acc[rd_ptr] to downstream
// CLEAR  | one cycle, zeroing the accumulator before the next frame
module poly_negacyclic_accumulator #(
  parameter int DEPTH = 100
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        B_valid,
  input  logic [9:0]  idx_B,
  input  logic [47:0] B_out,
  input  logic        last_in,
  input  logic        coef_ready_in,
  output logic        coef_valid_out,
  output logic [15:0] coef_out,
  output logic [9:0]  coef_idx_out,
  output logic        coef_last_out,
  output logic        busy_out,
  output logic        drop_err_out,
  output logic        range_err_out
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  localparam logic [10:0] DEPTH_K  = 11'(DEPTH);
  localparam logic [10:0] DEPTH2_K = 11'(2 * DEPTH);
  localparam logic [10:0] IDX_MAX  = 11'(2 * DEPTH - 2);
  localparam logic [9:0]  LAST_IDX = 10'(DEPTH - 1);

  logic [1:0]    state;
  logic [9:0]    rd_ptr;
  logic [15:0]   acc [DEPTH];

  logic          accepting;
  logic          in_range;
  logic          beat_upd;
  logic          handshake;
  logic [10:0]   lane_k    [3];
  logic [AW-1:0] lane_addr [3];
  logic          lane_neg  [3];
  logic [15:0]   lane_val  [3];

  assign accepting = (state == S_IDLE) || (state == S_ACCUM);
  assign in_range  = ({1'b0, idx_B} <= IDX_MAX);
  assign beat_upd  = B_valid && accepting && in_range;
  assign handshake = (state == S_DRAIN) && coef_ready_in;

  // Fold each lane's index into the ring: wrapped indices subtract, 2*DEPTH adds back at 0.
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      lane_k[j]    = {1'b0, idx_B} + 11'(j);
      lane_val[j]  = B_out[16*j +: 16];
      lane_addr[j] = '0;
      lane_neg[j]  = 1'b0;
      if (lane_k[j] < DEPTH_K) begin
        lane_addr[j] = lane_k[j][AW-1:0];
      end else if (lane_k[j] < DEPTH2_K) begin
        lane_addr[j] = AW'(lane_k[j] - DEPTH_K);
        lane_neg[j]  = 1'b1;
      end
    end
  end

  // Accumulator array: three distinct-address updates per beat, bulk clear after drain.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
    end else if (state == S_CLEAR) begin
      for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
    end else if (beat_upd) begin
      for (int j = 0; j < 3; j++) begin
        if (lane_neg[j]) acc[lane_addr[j]] <= acc[lane_addr[j]] - lane_val[j];
        else             acc[lane_addr[j]] <= acc[lane_addr[j]] + lane_val[j];
      end
    end
  end

  // Frame sequencing and drain read pointer.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state  <= S_IDLE;
      rd_ptr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (B_valid) state <= last_in ? S_DRAIN : S_ACCUM;
        end
        S_ACCUM: begin
          if (B_valid && last_in) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (handshake) begin
            if (rd_ptr == LAST_IDX) begin
              rd_ptr <= '0;
              state  <= S_CLEAR;
            end else begin
              rd_ptr <= rd_ptr + 10'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      drop_err_out  <= 1'b0;
      range_err_out <= 1'b0;
    end else begin
      if (B_valid && !accepting)              drop_err_out  <= 1'b1;
      if (B_valid && accepting && !in_range)  range_err_out <= 1'b1;
    end
  end

  assign coef_valid_out = (state == S_DRAIN);
  assign coef_out       = coef_valid_out ? acc[rd_ptr[AW-1:0]] : 16'd0;
  assign coef_idx_out   = coef_valid_out ? rd_ptr : 10'd0;
  assign coef_last_out  = coef_valid_out && (rd_ptr == LAST_IDX);
  assign busy_out       = (state == S_DRAIN) || (state == S_CLEAR);

endmodule

// File: tb/tb_poly_negacyclic_accumulator.sv
// Directed bench for poly_negacyclic_accumulator at DEPTH=4 with hand-computed frames.
module tb_poly_negacyclic_accumulator;

  logic        clk_in;
  logic        rst_n_in;
  logic        B_valid;
  logic [9:0]  idx_B;
  logic [47:0] B_out;
  logic        last_in;
  logic        coef_ready_in;
  logic        coef_valid_out;
  logic [15:0] coef_out;
  logic [9:0]  coef_idx_out;
  logic        coef_last_out;
  logic        busy_out;
  logic        drop_err_out;
  logic        range_err_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] cap_coef [4];
  logic [9:0]  cap_idx  [4];
  logic        cap_last [4];
  int          cap_n;

  poly_negacyclic_accumulator #(.DEPTH(4)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .B_valid       (B_valid),
    .idx_B         (idx_B),
    .B_out         (B_out),
    .last_in       (last_in),
    .coef_ready_in (coef_ready_in),
    .coef_valid_out(coef_valid_out),
    .coef_out      (coef_out),
    .coef_idx_out  (coef_idx_out),
    .coef_last_out (coef_last_out),
    .busy_out      (busy_out),
    .drop_err_out  (drop_err_out),
    .range_err_out (range_err_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Present one beat for exactly one rising edge.
  task automatic send_beat(input logic [9:0] idx, input logic [47:0] b, input logic last);
    @(negedge clk_in);
    B_valid = 1'b1;
    idx_B   = idx;
    B_out   = b;
    last_in = last;
    @(posedge clk_in);
    #1;
    B_valid = 1'b0;
    last_in = 1'b0;
  endtask

  // Capture up to four drained coefficients with ready held high, bounded in cycles.
  task automatic collect_frame();
    cap_n = 0;
    for (int i = 0; i < 4; i++) begin
      cap_coef[i] = 16'hDEAD;
      cap_idx[i]  = 10'h3FF;
      cap_last[i] = 1'b0;
    end
    coef_ready_in = 1'b1;
    for (int g = 0; g < 40 && cap_n < 4; g++) begin
      @(negedge clk_in);
      if (coef_valid_out) begin
        cap_coef[cap_n] = coef_out;
        cap_idx[cap_n]  = coef_idx_out;
        cap_last[cap_n] = coef_last_out;
        cap_n++;
      end
    end
    @(negedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({coef_valid_out, coef_out, coef_idx_out, coef_last_out, busy_out, drop_err_out, range_err_out} !== 31'd0) begin
      n_bad++;
      $display("FAIL reset_hold: outputs got %h want 0",
               {coef_valid_out, coef_out, coef_idx_out, coef_last_out, busy_out, drop_err_out, range_err_out});
    end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    n_cmp++;
    if ({coef_valid_out, busy_out, drop_err_out, range_err_out} !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_release: valid/busy/drop/range got %b want 0000",
               {coef_valid_out, busy_out, drop_err_out, range_err_out});
    end
  endtask

  task automatic test_single_beat();
    logic [15:0] exp_c [4] = '{16'd1, 16'd2, 16'd3, 16'd0};
    send_beat(10'd0, {16'd3, 16'd2, 16'd1}, 1'b1);
    collect_frame();
    n_cmp++;
    if (cap_n != 4) begin
      n_bad++;
      $display("FAIL single_count: got %0d coefficients want 4", cap_n);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (cap_coef[i] !== exp_c[i] || cap_idx[i] !== 10'(i) || cap_last[i] !== (i == 3)) begin
        n_bad++;
        $display("FAIL single_coef[%0d]: got %h idx %0d last %b want %h idx %0d last %b",
                 i, cap_coef[i], cap_idx[i], cap_last[i], exp_c[i], i, (i == 3));
      end
    end
    n_cmp++;
    if (busy_out !== 1'b0 || coef_valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL single_idle: busy %b valid %b want 0 0", busy_out, coef_valid_out);
    end
  endtask

  task automatic test_negwrap();
    logic [15:0] exp_c [4] = '{16'hFFFB, 16'hFFF9, 16'h0000, 16'd10};
    send_beat(10'd3, {16'd7, 16'd5, 16'd10}, 1'b1);
    collect_frame();
    n_cmp++;
    if (cap_n != 4) begin
      n_bad++;
      $display("FAIL negwrap_count: got %0d want 4", cap_n);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (cap_coef[i] !== exp_c[i] || cap_idx[i] !== 10'(i)) begin
        n_bad++;
        $display("FAIL negwrap_coef[%0d]: got %h idx %0d want %h idx %0d",
                 i, cap_coef[i], cap_idx[i], exp_c[i], i);
      end
    end
  endtask

  task automatic test_top_index();
    logic [15:0] exp_a [4] = '{16'h0000, 16'h0000, 16'hFFFC, 16'hFFF7};
    logic [15:0] exp_b [4] = '{16'd5,    16'h0000, 16'hFFFC, 16'hFFF7};
    send_beat(10'd6, {16'd0, 16'd9, 16'd4}, 1'b1);
    collect_frame();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (cap_coef[i] !== exp_a[i]) begin
        n_bad++;
        $display("FAIL top_idx_a[%0d]: got %h want %h", i, cap_coef[i], exp_a[i]);
      end
    end
    send_beat(10'd6, {16'd5, 16'd9, 16'd4}, 1'b1);
    collect_frame();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (cap_coef[i] !== exp_b[i]) begin
        n_bad++;
        $display("FAIL top_idx_b[%0d]: got %h want %h", i, cap_coef[i], exp_b[i]);
      end
    end
    n_cmp++;
    if (range_err_out !== 1'b0) begin
      n_bad++;
      $display("FAIL top_idx_range: range_err got %b want 0", range_err_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_c [4] = '{16'd0, 16'h0001, 16'd0, 16'd0};
    send_beat(10'd1, {16'd0, 16'd0, 16'hFFFF}, 1'b0);
    #2;
    n_cmp++;
    if (coef_valid_out !== 1'b0 || busy_out !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_accum: valid %b busy %b want 0 0", coef_valid_out, busy_out);
    end
    send_beat(10'd1, {16'd0, 16'd0, 16'h0002}, 1'b1);
    collect_frame();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (cap_coef[i] !== exp_c[i] || cap_idx[i] !== 10'(i)) begin
        n_bad++;
        $display("FAIL b2b_coef[%0d]: got %h idx %0d want %h idx %0d",
                 i, cap_coef[i], cap_idx[i], exp_c[i], i);
      end
    end
  endtask

  task automatic test_backpressure();
    coef_ready_in = 1'b1;
    send_beat(10'd0, {16'd30, 16'd20, 16'd10}, 1'b1);
    @(negedge clk_in);
    n_cmp++;
    if (coef_valid_out !== 1'b1 || coef_idx_out !== 10'd0 || coef_out !== 16'd10) begin
      n_bad++;
      $display("FAIL bp_step0: valid %b idx %0d coef %0d want 1 0 10", coef_valid_out, coef_idx_out, coef_out);
    end
    @(negedge clk_in);
    n_cmp++;
    if (coef_idx_out !== 10'd1 || coef_out !== 16'd20) begin
      n_bad++;
      $display("FAIL bp_step1: idx %0d coef %0d want 1 20", coef_idx_out, coef_out);
    end
    coef_ready_in = 1'b0;
    @(negedge clk_in);
    n_cmp++;
    if (coef_valid_out !== 1'b1 || coef_idx_out !== 10'd1 || coef_out !== 16'd20) begin
      n_bad++;
      $display("FAIL bp_hold1: valid %b idx %0d coef %0d want 1 1 20", coef_valid_out, coef_idx_out, coef_out);
    end
    B_valid = 1'b1;
    idx_B   = 10'd1;
    B_out   = {16'd7, 16'd7, 16'd7};
    @(posedge clk_in);
    #1;
    B_valid = 1'b0;
    @(negedge clk_in);
    n_cmp++;
    if (coef_idx_out !== 10'd1 || coef_out !== 16'd20 || drop_err_out !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_hold2_drop: idx %0d coef %0d drop %b want 1 20 1", coef_idx_out, coef_out, drop_err_out);
    end
    coef_ready_in = 1'b1;
    @(negedge clk_in);
    n_cmp++;
    if (coef_idx_out !== 10'd2 || coef_out !== 16'd30 || coef_last_out !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_step2: idx %0d coef %0d last %b want 2 30 0", coef_idx_out, coef_out, coef_last_out);
    end
    @(negedge clk_in);
    n_cmp++;
    if (coef_idx_out !== 10'd3 || coef_out !== 16'd0 || coef_last_out !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_step3: idx %0d coef %0d last %b want 3 0 1", coef_idx_out, coef_out, coef_last_out);
    end
    @(negedge clk_in);
    n_cmp++;
    if (busy_out !== 1'b1 || coef_valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_clear: busy %b valid %b want 1 0", busy_out, coef_valid_out);
    end
    @(negedge clk_in);
  endtask

  task automatic test_range();
    send_beat(10'd7, {16'd1, 16'd1, 16'd1}, 1'b1);
    n_cmp++;
    if (range_err_out !== 1'b1) begin
      n_bad++;
      $display("FAIL range_flag: range_err got %b want 1", range_err_out);
    end
    collect_frame();
    n_cmp++;
    if (cap_n != 4) begin
      n_bad++;
      $display("FAIL range_count: got %0d want 4", cap_n);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (cap_coef[i] !== 16'd0) begin
        n_bad++;
        $display("FAIL range_coef[%0d]: got %h want 0000", i, cap_coef[i]);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    n_cmp++;
    if (drop_err_out !== 1'b1 || range_err_out !== 1'b1) begin
      n_bad++;
      $display("FAIL sticky_hold: drop %b range %b want 1 1", drop_err_out, range_err_out);
    end
    coef_ready_in = 1'b0;
    send_beat(10'd0, {16'd3, 16'd2, 16'd1}, 1'b1);
    @(negedge clk_in);
    n_cmp++;
    if (coef_valid_out !== 1'b1 || coef_out !== 16'd1) begin
      n_bad++;
      $display("FAIL mid_drain_pre: valid %b coef %0d want 1 1", coef_valid_out, coef_out);
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    n_cmp++;
    if ({coef_valid_out, busy_out, drop_err_out, range_err_out} !== 4'd0) begin
      n_bad++;
      $display("FAIL mid_drain_rst: valid/busy/drop/range got %b want 0000",
               {coef_valid_out, busy_out, drop_err_out, range_err_out});
    end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    send_beat(10'd0, 48'd0, 1'b1);
    collect_frame();
    n_cmp++;
    if (cap_n != 4) begin
      n_bad++;
      $display("FAIL post_rst_count: got %0d want 4", cap_n);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (cap_coef[i] !== 16'd0) begin
        n_bad++;
        $display("FAIL post_rst_coef[%0d]: got %h want 0000", i, cap_coef[i]);
      end
    end
  endtask

  initial begin
    rst_n_in      = 1'b0;
    B_valid       = 1'b0;
    idx_B         = '0;
    B_out         = '0;
    last_in       = 1'b0;
    coef_ready_in = 1'b1;
    test_reset();
    test_single_beat();
    test_negwrap();
    test_top_index();
    test_back_to_back();
    test_backpressure();
    test_range();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
